// File: rtl/upl_pkg.sv
// Shared UPL receive definitions: header word layout, decoded header type and unpacker states.
package upl_pkg;

  localparam logic [1:0] UPL_W_SRCIP = 2'd0;
  localparam logic [1:0] UPL_W_DSTIP = 2'd1;
  localparam logic [1:0] UPL_W_PORTS = 2'd2;
  localparam logic [1:0] UPL_W_LEN   = 2'd3;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } upl_hdr_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACK     = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;

endpackage

// File: rtl/upl_udp_rx_unpack.sv
// UDP receive UPL unpacker: Request/Ack handshake, 4-word header decode, payload
// re-emitted with byte keep / last, optional destination-port filter and counters.
module upl_udp_rx_unpack
  import upl_pkg::*;
#(
  parameter int          PORT_FILTER = 1,
  parameter logic [15:0] MY_PORT     = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        UPLin_Request,
  output logic        UPLin_Ack,
  input  logic        UPLin_Enable,
  input  logic [31:0] UPLin_Data,
  output logic        hdr_valid,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] length,
  output logic        pl_valid,
  output logic [31:0] pl_data,
  output logic [3:0]  pl_keep,
  output logic        pl_last,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count,
  output logic [15:0] err_count
);

  localparam bit FILTER_ON = (PORT_FILTER != 0);

  logic [2:0]  state;
  logic [1:0]  idx;
  logic [31:0] w0_q;
  logic [31:0] w1_q;
  logic [31:0] w2_q;
  logic [15:0] remaining;
  logic        emitted;
  upl_hdr_t    hdr;

  assign src_ip   = hdr.src_ip;
  assign dst_ip   = hdr.dst_ip;
  assign src_port = hdr.src_port;
  assign dst_port = hdr.dst_port;
  assign length   = hdr.length;

  function automatic logic [3:0] keep_from_rem(input logic [15:0] rem);
    case (rem)
      16'd1:   keep_from_rem = 4'b1000;
      16'd2:   keep_from_rem = 4'b1100;
      16'd3:   keep_from_rem = 4'b1110;
      default: keep_from_rem = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      remaining  <= '0;
      emitted    <= 1'b0;
      hdr        <= '0;
      UPLin_Ack  <= 1'b0;
      hdr_valid  <= 1'b0;
      pl_valid   <= 1'b0;
      pl_data    <= '0;
      pl_keep    <= '0;
      pl_last    <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      hdr_valid <= 1'b0;
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      pl_keep   <= '0;
      case (state)
        ST_IDLE: begin
          if (UPLin_Request) begin
            UPLin_Ack <= 1'b1;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (UPLin_Enable) begin
            UPLin_Ack <= 1'b0;
            w0_q      <= UPLin_Data;
            idx       <= UPL_W_SRCIP + 2'd1;
            state     <= ST_HDR;
          end else if (!UPLin_Request) begin
            UPLin_Ack <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (!UPLin_Enable) begin
            err_count <= err_count + 16'd1;
            state     <= ST_IDLE;
          end else begin
            idx <= idx + 2'd1;
            case (idx)
              UPL_W_DSTIP: w1_q <= UPLin_Data;
              UPL_W_PORTS: w2_q <= UPLin_Data;
              UPL_W_LEN: begin
                hdr <= '{src_ip: w0_q, dst_ip: w1_q, src_port: w2_q[31:16],
                         dst_port: w2_q[15:0], length: UPLin_Data[15:0]};
                hdr_valid <= 1'b1;
                remaining <= UPLin_Data[15:0];
                emitted   <= 1'b0;
                // Filtering wins over the zero-length shortcut so drops are always counted.
                if (FILTER_ON && (w2_q[15:0] != MY_PORT)) begin
                  state <= ST_DROP;
                end else if (UPLin_Data[15:0] == 16'd0) begin
                  pkt_count <= pkt_count + 16'd1;
                  state     <= ST_IDLE;
                end else begin
                  state <= ST_PAYLOAD;
                end
              end
              default: ;
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (UPLin_Enable) begin
            pl_valid <= 1'b1;
            pl_data  <= UPLin_Data;
            emitted  <= 1'b1;
            if (remaining <= 16'd4) begin
              pl_last   <= 1'b1;
              pl_keep   <= keep_from_rem(remaining);
              pkt_count <= pkt_count + 16'd1;
              state     <= ST_IDLE;
            end else begin
              pl_keep   <= 4'hF;
              remaining <= remaining - 16'd4;
            end
          end else begin
            // pl_last without pl_valid tells the consumer the packet was cut short.
            pl_last   <= emitted;
            err_count <= err_count + 16'd1;
            state     <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!UPLin_Enable) begin
            drop_count <= drop_count + 16'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upl_udp_rx_unpack.sv
// Directed bench for upl_udp_rx_unpack: filtering and non-filtering instances share stimulus.
module tb_upl_udp_rx_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data = '0;

  logic        ack, hdr_valid, pl_valid, pl_last;
  logic [31:0] src_ip, dst_ip, pl_data;
  logic [15:0] src_port, dst_port, length, pkt_count, drop_count, err_count;
  logic [3:0]  pl_keep;

  logic        nf_ack, nf_hdr_valid, nf_pl_valid, nf_pl_last;
  logic [31:0] nf_src_ip, nf_dst_ip, nf_pl_data;
  logic [15:0] nf_src_port, nf_dst_port, nf_length, nf_pkt_count, nf_drop_count, nf_err_count;
  logic [3:0]  nf_pl_keep;

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0, exp_drop = 0, exp_err = 0;

  logic [31:0] words [0:15];

  logic [31:0] mon_data [$];
  logic [3:0]  mon_keep [$];
  logic        mon_last [$];
  logic [31:0] nf_q [$];
  int          hdr_cnt = 0;
  int          abort_cnt = 0;

  always #5 clk = ~clk;

  upl_udp_rx_unpack #(.PORT_FILTER(1), .MY_PORT(16'h4000)) dut (
    .clk(clk), .reset(reset), .UPLin_Request(req), .UPLin_Ack(ack),
    .UPLin_Enable(en), .UPLin_Data(data), .hdr_valid(hdr_valid),
    .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .length(length), .pl_valid(pl_valid), .pl_data(pl_data), .pl_keep(pl_keep),
    .pl_last(pl_last), .pkt_count(pkt_count), .drop_count(drop_count), .err_count(err_count)
  );

  upl_udp_rx_unpack #(.PORT_FILTER(0), .MY_PORT(16'h4000)) dut_nf (
    .clk(clk), .reset(reset), .UPLin_Request(req), .UPLin_Ack(nf_ack),
    .UPLin_Enable(en), .UPLin_Data(data), .hdr_valid(nf_hdr_valid),
    .src_ip(nf_src_ip), .dst_ip(nf_dst_ip), .src_port(nf_src_port), .dst_port(nf_dst_port),
    .length(nf_length), .pl_valid(nf_pl_valid), .pl_data(nf_pl_data), .pl_keep(nf_pl_keep),
    .pl_last(nf_pl_last), .pkt_count(nf_pkt_count), .drop_count(nf_drop_count),
    .err_count(nf_err_count)
  );

  always @(negedge clk) begin
    if (pl_valid) begin
      mon_data.push_back(pl_data);
      mon_keep.push_back(pl_keep);
      mon_last.push_back(pl_last);
    end
    if (pl_last && !pl_valid) abort_cnt++;
    if (hdr_valid) hdr_cnt++;
    if (nf_pl_valid) nf_q.push_back(nf_pl_data);
  end

  task automatic set_hdr(input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
    words[0] = sip;
    words[1] = dip;
    words[2] = {sp, dp};
    words[3] = {16'h0, len};
  endtask

  task automatic wait_ack(input string name);
    int t = 0;
    while (!ack && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack_timeout got %b want 1", name, ack);
    end
  endtask

  task automatic drive_pkt(input int n, input bit hold_req);
    @(negedge clk);
    req = 1'b1;
    wait_ack("drive");
    for (int i = 0; i < n; i++) begin
      en   = 1'b1;
      data = words[i];
      if (i == 0 && !hold_req) req = 1'b0;
      @(negedge clk);
    end
    en   = 1'b0;
    data = '0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, hdr_valid, pl_valid, pl_last} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {ack, hdr_valid, pl_valid, pl_last});
    end
    checks++;
    if ({pkt_count, drop_count, err_count} !== 48'h0) begin
      errors++; $display("FAIL reset_counters got %h want 0", {pkt_count, drop_count, err_count});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int h0 = hdr_cnt;
    int b = mon_data.size();
    set_hdr(32'h0A000001, 32'h0A000002, 16'h1234, 16'h4000, 16'd8);
    words[4] = 32'h01020304;
    words[5] = 32'h05060708;
    drive_pkt(6, 1'b0);
    repeat (2) @(negedge clk);
    exp_pkt++;
    checks++;
    if (hdr_cnt - h0 != 1) begin errors++; $display("FAIL basic_hdr_cnt got %0d want 1", hdr_cnt - h0); end
    checks++;
    if ({src_ip, dst_ip} !== {32'h0A000001, 32'h0A000002}) begin
      errors++; $display("FAIL basic_ips got %h %h want 0a000001 0a000002", src_ip, dst_ip);
    end
    checks++;
    if ({src_port, dst_port, length} !== {16'h1234, 16'h4000, 16'd8}) begin
      errors++; $display("FAIL basic_ports_len got %h %h %h want 1234 4000 0008", src_port, dst_port, length);
    end
    checks++;
    if (mon_data.size() - b != 2) begin
      errors++; $display("FAIL basic_pl_cnt got %0d want 2", mon_data.size() - b);
    end else begin
      checks++;
      if ({mon_data[b], mon_data[b+1]} !== {32'h01020304, 32'h05060708}) begin
        errors++; $display("FAIL basic_pl_data got %h %h want 01020304 05060708", mon_data[b], mon_data[b+1]);
      end
      checks++;
      if ({mon_keep[b], mon_keep[b+1], mon_last[b], mon_last[b+1]} !== 10'b1111_1111_0_1) begin
        errors++; $display("FAIL basic_keep_last got %h %h %b %b want f f 0 1",
                           mon_keep[b], mon_keep[b+1], mon_last[b], mon_last[b+1]);
      end
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt)) begin errors++; $display("FAIL basic_pkt_count got %0d want %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_len5_len0;
    int h0 = hdr_cnt;
    int b = mon_data.size();
    set_hdr(32'hC0A80001, 32'hC0A80002, 16'h0050, 16'h4000, 16'd5);
    words[4] = 32'hAABBCCDD;
    words[5] = 32'hEE000000;
    drive_pkt(6, 1'b0);
    repeat (2) @(negedge clk);
    exp_pkt++;
    checks++;
    if (mon_data.size() - b != 2) begin
      errors++; $display("FAIL len5_pl_cnt got %0d want 2", mon_data.size() - b);
    end else begin
      checks++;
      if ({mon_keep[b], mon_last[b], mon_keep[b+1], mon_last[b+1]} !== 10'b1111_0_1000_1) begin
        errors++; $display("FAIL len5_keep_last got %h %b %h %b want f 0 8 1",
                           mon_keep[b], mon_last[b], mon_keep[b+1], mon_last[b+1]);
      end
    end
    b  = mon_data.size();
    h0 = hdr_cnt;
    set_hdr(32'h01010101, 32'h02020202, 16'h0007, 16'h4000, 16'd0);
    drive_pkt(4, 1'b0);
    repeat (2) @(negedge clk);
    exp_pkt++;
    checks++;
    if (hdr_cnt - h0 != 1 || length !== 16'd0) begin
      errors++; $display("FAIL len0_hdr got cnt %0d len %0d want 1 0", hdr_cnt - h0, length);
    end
    checks++;
    if (mon_data.size() != b) begin errors++; $display("FAIL len0_no_pl got %0d want 0", mon_data.size() - b); end
    checks++;
    if (pkt_count !== 16'(exp_pkt)) begin errors++; $display("FAIL len0_pkt_count got %0d want %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_filter;
    int h0 = hdr_cnt;
    int b = mon_data.size();
    int nb = nf_q.size();
    set_hdr(32'h0A000003, 32'h0A000004, 16'h2222, 16'h4001, 16'd8);
    words[4] = 32'h11111111;
    words[5] = 32'h22222222;
    drive_pkt(6, 1'b0);
    repeat (2) @(negedge clk);
    exp_drop++;
    checks++;
    if (hdr_cnt - h0 != 1 || dst_port !== 16'h4001) begin
      errors++; $display("FAIL filter_hdr got cnt %0d port %h want 1 4001", hdr_cnt - h0, dst_port);
    end
    checks++;
    if (mon_data.size() != b) begin errors++; $display("FAIL filter_no_pl got %0d want 0", mon_data.size() - b); end
    checks++;
    if (drop_count !== 16'(exp_drop) || pkt_count !== 16'(exp_pkt)) begin
      errors++; $display("FAIL filter_counts got drop %0d pkt %0d want %0d %0d", drop_count, pkt_count, exp_drop, exp_pkt);
    end
    checks++;
    if (nf_q.size() - nb != 2) begin
      errors++; $display("FAIL nofilter_pl_cnt got %0d want 2", nf_q.size() - nb);
    end else begin
      checks++;
      if ({nf_q[nb], nf_q[nb+1]} !== {32'h11111111, 32'h22222222}) begin
        errors++; $display("FAIL nofilter_pl_data got %h %h want 11111111 22222222", nf_q[nb], nf_q[nb+1]);
      end
    end
  endtask

  task automatic test_truncate;
    int b = mon_data.size();
    int a0 = abort_cnt;
    set_hdr(32'h0A000005, 32'h0A000006, 16'h3333, 16'h4000, 16'd16);
    words[4] = 32'hDEAD0001;
    words[5] = 32'hDEAD0002;
    drive_pkt(6, 1'b0);
    repeat (2) @(negedge clk);
    exp_err++;
    checks++;
    if (mon_data.size() - b != 2) begin
      errors++; $display("FAIL trunc_pl_cnt got %0d want 2", mon_data.size() - b);
    end else begin
      checks++;
      if ({mon_last[b], mon_last[b+1]} !== 2'b00) begin
        errors++; $display("FAIL trunc_no_last got %b%b want 00", mon_last[b], mon_last[b+1]);
      end
    end
    checks++;
    if (abort_cnt - a0 != 1) begin errors++; $display("FAIL trunc_abort got %0d want 1", abort_cnt - a0); end
    checks++;
    if (err_count !== 16'(exp_err) || pkt_count !== 16'(exp_pkt)) begin
      errors++; $display("FAIL trunc_counts got err %0d pkt %0d want %0d %0d", err_count, pkt_count, exp_err, exp_pkt);
    end
  endtask

  task automatic test_back_to_back;
    int h0 = hdr_cnt;
    int b = mon_data.size();
    set_hdr(32'h0A000007, 32'h0A000008, 16'h4444, 16'h4000, 16'd4);
    words[4] = 32'hCAFEF00D;
    drive_pkt(5, 1'b1);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_early got %b want 0", ack); end
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_gap got %b want 1", ack); end
    set_hdr(32'h0A000009, 32'h0A00000A, 16'h5555, 16'h4000, 16'd4);
    words[4] = 32'h12345678;
    drive_pkt(5, 1'b0);
    repeat (2) @(negedge clk);
    exp_pkt += 2;
    checks++;
    if (hdr_cnt - h0 != 2 || src_ip !== 32'h0A000009) begin
      errors++; $display("FAIL b2b_hdr got cnt %0d src %h want 2 0a000009", hdr_cnt - h0, src_ip);
    end
    checks++;
    if (mon_data.size() - b != 2) begin
      errors++; $display("FAIL b2b_pl_cnt got %0d want 2", mon_data.size() - b);
    end else begin
      checks++;
      if ({mon_data[b], mon_data[b+1], mon_last[b], mon_last[b+1], mon_keep[b], mon_keep[b+1]}
          !== {32'hCAFEF00D, 32'h12345678, 2'b11, 8'hFF}) begin
        errors++; $display("FAIL b2b_pl got %h %h last %b%b keep %h %h want cafef00d 12345678 11 f f",
                           mon_data[b], mon_data[b+1], mon_last[b], mon_last[b+1], mon_keep[b], mon_keep[b+1]);
      end
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt)) begin errors++; $display("FAIL b2b_pkt_count got %0d want %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_reset_mid;
    int b;
    set_hdr(32'h0A00000B, 32'h0A00000C, 16'h6666, 16'h4000, 16'd12);
    words[4] = 32'h99999999;
    @(negedge clk);
    req = 1'b1;
    wait_ack("rstmid");
    for (int i = 0; i < 5; i++) begin
      en   = 1'b1;
      data = words[i];
      if (i == 0) req = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (pl_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", pl_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pl_valid, pl_last, hdr_valid, ack, pl_keep} !== 8'h0 || pl_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_async_out got %b %h want 0 0", {pl_valid, pl_last, hdr_valid, ack, pl_keep}, pl_data);
    end
    checks++;
    if ({src_ip, length, pkt_count, drop_count, err_count} !== 96'h0) begin
      errors++; $display("FAIL rstmid_async_regs got %h %h %h %h %h want 0",
                         src_ip, length, pkt_count, drop_count, err_count);
    end
    en = 1'b0;
    data = '0;
    @(negedge clk);
    reset = 1'b0;
    exp_pkt = 0; exp_drop = 0; exp_err = 0;
    b = mon_data.size();
    set_hdr(32'h0A00000D, 32'h0A00000E, 16'h7777, 16'h4000, 16'd3);
    words[4] = 32'h11223300;
    drive_pkt(5, 1'b0);
    repeat (2) @(negedge clk);
    exp_pkt++;
    checks++;
    if (length !== 16'd3 || src_ip !== 32'h0A00000D) begin
      errors++; $display("FAIL rstmid_next_hdr got %h %h want 0a00000d 0003", src_ip, length);
    end
    checks++;
    if (mon_data.size() - b != 1) begin
      errors++; $display("FAIL rstmid_next_pl_cnt got %0d want 1", mon_data.size() - b);
    end else begin
      checks++;
      if ({mon_data[b], mon_keep[b], mon_last[b]} !== {32'h11223300, 4'b1110, 1'b1}) begin
        errors++; $display("FAIL rstmid_next_pl got %h %b %b want 11223300 1110 1", mon_data[b], mon_keep[b], mon_last[b]);
      end
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt)) begin errors++; $display("FAIL rstmid_pkt_count got %0d want %0d", pkt_count, exp_pkt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len5_len0();
    test_filter();
    test_truncate();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/upl_udp_rx_unpack.md
# upl_udp_rx_unpack

Receive-side unpacker between the UDP/IP core's UDP receive UPL port and user logic. Accepts one UPL packet at a time: handshake via Request/Ack, then a contiguous Enable-qualified word stream. Decodes the 4-word UDP header into registered fields and re-emits the payload as a word stream with byte-keep and last markers. Packets whose destination port does not match are optionally dropped, and packet/drop/error counts are exposed.

## Interface
- PORT_FILTER, default 1: 1 = drop packets whose dst_port ≠ MY_PORT.
- MY_PORT, default 16'h4000: accepted destination UDP port.
- clk  in  1  system clock (125 MHz domain).
- reset  in  1  asynchronous, active-high.
- UPLin_Request  in  1  core has a packet pending.
- UPLin_Ack  out  1  packet accepted.
- UPLin_Enable  in  1  data word valid; contiguous for the whole packet.
- UPLin_Data  in  32  packet word.
- hdr_valid  out  1  1-cycle pulse: header fields valid.
- src_ip, dst_ip  out  32  header fields, held until next hdr_valid.
- src_port, dst_port  out  16  header fields.
- length  out  16  payload length in bytes.
- pl_valid  out  1  payload word valid.
- pl_data  out  32  payload word, first byte in [31:24].
- pl_keep  out  4  valid bytes, MSB-first.
- pl_last  out  1  final payload word.
- pkt_count, drop_count, err_count  out  16  saturating-free wrapping counters.

## Operation
- Packet format: w0 src_ip, w1 dst_ip, w2 {src_port, dst_port}, w3 {16'h0, length}, then ceil(length/4) payload words.
- FSM: IDLE → ACK → HDR → PAYLOAD or DROP → IDLE.
- IDLE: UPLin_Ack=0. Request=1 → ACK.
- ACK: UPLin_Ack=1 until the first Enable word; then Ack=0 and enter HDR, that word counting as w0.
- HDR: word index 0..3 captured. At w3: hdr_valid pulses. Then go to PAYLOAD if not filtered, else DROP. If length=0 → IDLE directly; pkt_count increments, no payload words are emitted.
- PAYLOAD: each Enable word → pl_valid with pl_data=UPLin_Data. A 16-bit remaining-byte counter is decremented by 4 per word. On the word with remaining ≤4: pl_last=1, pl_keep = 4'b1000/1100/1110/1111 for remaining 1/2/3/4, pkt_count++, → IDLE. Otherwise pl_keep=4'hF.
- DROP: consume words without output until Enable falls; drop_count++ and → IDLE. hdr_valid still pulses for dropped packets.
- Truncation: Enable low in HDR or PAYLOAD before the expected end → err_count++, → IDLE. If payload words were already emitted, one pl_valid=0/pl_last=1 cycle marks the abort; consumers treat pl_last without pl_valid as abort.
- Surplus words after pl_last: ignored in IDLE; Enable is not checked in IDLE.
- No backpressure: the consumer must accept one word per clock.

## Timing
- Reset (async assert, sync deassert by the upstream resetgen): state IDLE; all outputs 0, counters 0.
- All outputs are registered. Payload latency is 1 clock from UPLin_Enable/Data to pl_valid/pl_data.
- hdr_valid is asserted the cycle after w3 is sampled, coincident with the registered fields.
- Back-to-back packets: IDLE→ACK takes 1 cycle after the last word. Minimum gap from the last data word to the next Ack is 2 cycles.
- Request dropping while in ACK with no Enable: return to IDLE, no counter change.

## Structure
- Shared package upl_pkg: UPL header word indices (UPL_W_SRCIP=0 … UPL_W_LEN=3), the header struct type (src_ip, dst_ip, src_port, dst_port, length), and the FSM state enum.
- Single module; no sub-module needed. The keep-from-remaining decode is a local function.

## Test plan
- Packet dst_port 0x4000, length 8, payload 0x01020304, 0x05060708 → hdr_valid once; two pl_valid words; pl_last on the second with keep 4'hF; pkt_count=1.
- length 5 → second word keep 4'b1000 with pl_last; length 0 → hdr_valid only, no pl_valid, pkt_count increments.
- dst_port 0x4001 with PORT_FILTER=1 → no pl_valid, drop_count=1; with PORT_FILTER=0 → payload passes.
- Enable deasserted after 2 of 4 payload words → pl_last with pl_valid=0 on abort cycle, err_count=1, FSM back to IDLE.
- Two packets back-to-back with Request held high → Ack re-asserted 2 cycles after the first packet ends, both decoded, pkt_count=2.
- Reset asserted mid-payload → outputs go 0 asynchronously; the next packet after reset decodes correctly.
